// File: rtl/jtag_shift_engine_if.sv
// Command/status and pin bundle between the XVC register block, the JTAG shift
// engine and the JTAG pins. The master side issues shifts; the slave side is the engine.
interface jtag_shift_engine_if #(
  parameter int C_VEC_WIDTH = 32,
  parameter int C_DIV_WIDTH = 8
);
  logic                   start_i;
  logic                   abort_i;
  logic [31:0]            length_i;
  logic [C_DIV_WIDTH-1:0] half_period_i;
  logic [C_VEC_WIDTH-1:0] tms_vec_i;
  logic [C_VEC_WIDTH-1:0] tdi_vec_i;
  logic [C_VEC_WIDTH-1:0] tdo_vec_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;
  logic                   tck_o;
  logic                   tms_o;
  logic                   tdi_o;
  logic                   tdo_i;

  modport master (
    output start_i, abort_i, length_i, half_period_i, tms_vec_i, tdi_vec_i, tdo_i,
    input  tdo_vec_o, busy_o, done_o, err_o, tck_o, tms_o, tdi_o
  );

  modport slave (
    input  start_i, abort_i, length_i, half_period_i, tms_vec_i, tdi_vec_i, tdo_i,
    output tdo_vec_o, busy_o, done_o, err_o, tck_o, tms_o, tdi_o
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// Parametrised JTAG shift engine: serialises TMS/TDI LSB-first on a divided TCK
// and gathers TDO (sampled on TCK falling edges) into an index-ordered vector.
module jtag_shift_engine #(
  parameter int C_VEC_WIDTH = 32,
  parameter int C_DIV_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  jtag_shift_engine_if.slave bus
);

  localparam int IDX_W = $clog2(C_VEC_WIDTH) + 1;
  localparam int SEL_W = (C_VEC_WIDTH > 1) ? $clog2(C_VEC_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TCK_LOW,
    S_TCK_HIGH
  } state_t;

  state_t                 r_state;
  logic [C_DIV_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_tck;
  logic                   r_tms;
  logic                   r_tdi;
  logic                   r_done;
  logic                   r_err;
  logic [C_VEC_WIDTH-1:0] r_tdo;

  // Operands latched at accept; not reset since they are only read while busy.
  logic [C_VEC_WIDTH-1:0] r_tms_sh;
  logic [C_VEC_WIDTH-1:0] r_tdi_sh;
  logic [IDX_W-1:0]       r_len;
  logic [C_DIV_WIDTH-1:0] r_half;

  state_t                 w_state_nxt;
  logic [C_DIV_WIDTH-1:0] w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_tck_nxt;
  logic                   w_tms_nxt;
  logic                   w_tdi_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;
  logic [C_VEC_WIDTH-1:0] w_tdo_nxt;
  logic                   w_load;
  logic                   w_shift;

  logic                   w_phase_end;
  logic                   w_last_bit;
  logic                   w_len_zero;
  logic                   w_len_err;
  logic [SEL_W-1:0]       w_sel;
  logic [C_DIV_WIDTH-1:0] w_half_eff;

  assign w_phase_end = (r_cnt == r_half - C_DIV_WIDTH'(1));
  assign w_last_bit  = (r_idx == r_len - IDX_W'(1));
  assign w_len_zero  = (bus.length_i == 32'd0);
  assign w_len_err   = (bus.length_i > 32'(C_VEC_WIDTH));
  assign w_sel       = r_idx[SEL_W-1:0];
  assign w_half_eff  = (bus.half_period_i == '0) ? C_DIV_WIDTH'(1) : bus.half_period_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_tck_nxt   = r_tck;
    w_tms_nxt   = r_tms;
    w_tdi_nxt   = r_tdi;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_tdo_nxt   = r_tdo;
    w_load      = 1'b0;
    w_shift     = 1'b0;

    if (r_state != S_IDLE && bus.abort_i) begin
      // Abort drops the pins at once; bits already captured stay in r_tdo.
      w_state_nxt = S_IDLE;
      w_tck_nxt   = 1'b0;
      w_tms_nxt   = 1'b0;
      w_tdi_nxt   = 1'b0;
      w_done_nxt  = 1'b1;
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tck_nxt = 1'b0;
          w_tms_nxt = 1'b0;
          w_tdi_nxt = 1'b0;
          if (bus.start_i && !bus.abort_i) begin
            w_load    = 1'b1;
            w_tdo_nxt = '0;
            w_idx_nxt = '0;
            w_cnt_nxt = '0;
            if (w_len_zero) begin
              w_done_nxt = 1'b1;
            end else if (w_len_err) begin
              w_done_nxt = 1'b1;
              w_err_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_TCK_LOW;
              w_tms_nxt   = bus.tms_vec_i[0];
              w_tdi_nxt   = bus.tdi_vec_i[0];
            end
          end
        end

        S_TCK_LOW: begin
          if (w_phase_end) begin
            w_cnt_nxt   = '0;
            w_tck_nxt   = 1'b1;
            w_state_nxt = S_TCK_HIGH;
          end else begin
            w_cnt_nxt = r_cnt + C_DIV_WIDTH'(1);
          end
        end

        S_TCK_HIGH: begin
          if (w_phase_end) begin
            w_cnt_nxt        = '0;
            w_tck_nxt        = 1'b0;
            w_tdo_nxt[w_sel] = bus.tdo_i;
            if (w_last_bit) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_tms_nxt   = 1'b0;
              w_tdi_nxt   = 1'b0;
            end else begin
              // Next bit goes out on the falling edge, a full low phase ahead of TCK rise.
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_shift     = 1'b1;
              w_tms_nxt   = r_tms_sh[0];
              w_tdi_nxt   = r_tdi_sh[0];
              w_state_nxt = S_TCK_LOW;
            end
          end else begin
            w_cnt_nxt = r_cnt + C_DIV_WIDTH'(1);
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_tck_nxt   = 1'b0;
          w_tms_nxt   = 1'b0;
          w_tdi_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b0;
      r_tdi   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tdo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_tck   <= w_tck_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_tdo   <= w_tdo_nxt;
    end
  end

  // Shift registers hold the bits not yet presented; bit 0 goes out directly at accept.
  always_ff @(posedge clk_i) begin
    if (w_load) begin
      r_tms_sh <= bus.tms_vec_i >> 1;
      r_tdi_sh <= bus.tdi_vec_i >> 1;
      r_len    <= bus.length_i[IDX_W-1:0];
      r_half   <= w_half_eff;
    end else if (w_shift) begin
      r_tms_sh <= r_tms_sh >> 1;
      r_tdi_sh <= r_tdi_sh >> 1;
    end
  end

  assign bus.tdo_vec_o = r_tdo;
  assign bus.busy_o    = (r_state != S_IDLE);
  assign bus.done_o    = r_done;
  assign bus.err_o     = r_err;
  assign bus.tck_o     = r_tck;
  assign bus.tms_o     = r_tms;
  assign bus.tdi_o     = r_tdi;

endmodule
